// File: rtl/param_streamer.sv
// Streams per-layer parameter records from external memory onto the CiM bus.
// Each record is announced by a START instruction followed by packed DATA instructions.
module param_streamer #(
  parameter int N_STORAGE  = 16,
  parameter int NUM_CIMS   = 64,
  parameter int WPI        = 3,
  parameter int NUM_LAYERS = 8,
  parameter int ADDR_W     = 15,
  parameter int LEN_W      = 7,
  parameter int OP_START   = 1,
  parameter int OP_DATA    = 2,
  localparam int TW = (NUM_CIMS > 1) ? $clog2(NUM_CIMS) : 1,
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     cfg_we,
  input  logic [LW-1:0]            cfg_idx,
  input  logic [ADDR_W-1:0]        cfg_base,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic [LEN_W-1:0]         cfg_num_rec,
  input  logic                     cfg_bcast,
  output logic                     ext_req,
  output logic [ADDR_W-1:0]        ext_addr,
  input  logic                     ext_valid,
  input  logic [N_STORAGE-1:0]     ext_data,
  output logic                     bus_drive,
  output logic [3:0]               bus_op,
  output logic [WPI*N_STORAGE-1:0] bus_data,
  output logic [TW-1:0]            bus_target,
  output logic                     bus_bcast,
  output logic                     busy,
  output logic                     done
);

  localparam int SW = (WPI > 1) ? $clog2(WPI) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;

  logic [ADDR_W-1:0] tbl_base_q [NUM_LAYERS];
  logic [ADDR_W-1:0] tbl_base_d [NUM_LAYERS];
  logic [LEN_W-1:0]  tbl_len_q  [NUM_LAYERS];
  logic [LEN_W-1:0]  tbl_len_d  [NUM_LAYERS];
  logic [LEN_W-1:0]  tbl_num_q  [NUM_LAYERS];
  logic [LEN_W-1:0]  tbl_num_d  [NUM_LAYERS];
  logic              tbl_bc_q   [NUM_LAYERS];
  logic              tbl_bc_d   [NUM_LAYERS];

  logic [2:0]                          state_q, state_d;
  logic [LW-1:0]                       layer_q, layer_d;
  logic [LEN_W-1:0]                    rec_q, rec_d;
  logic [LEN_W-1:0]                    elem_q, elem_d;
  logic [SW-1:0]                       slot_q, slot_d;
  logic [ADDR_W-1:0]                   rec_base_q, rec_base_d;
  logic [WPI-1:0][N_STORAGE-1:0]       words_q, words_d;
  logic                                done_q, done_d;

  logic [ADDR_W-1:0]             cur_base;
  logic [LEN_W-1:0]              cur_len;
  logic [LEN_W-1:0]              cur_num;
  logic                          cur_bcast;
  logic                          cur_empty;
  logic                          last_layer;
  logic                          hdr_drive;
  logic                          data_drive;
  logic [WPI-1:0][N_STORAGE-1:0] hdr_words;

  assign cur_base   = tbl_base_q[layer_q];
  assign cur_len    = tbl_len_q[layer_q];
  assign cur_num    = tbl_num_q[layer_q];
  assign cur_bcast  = tbl_bc_q[layer_q];
  assign cur_empty  = (cur_len == '0) || (cur_num == '0);
  assign last_layer = (layer_q == LW'(NUM_LAYERS - 1));

  // The table is frozen for the whole stream so record geometry cannot shift mid-layer.
  always_comb begin
    tbl_base_d = tbl_base_q;
    tbl_len_d  = tbl_len_q;
    tbl_num_d  = tbl_num_q;
    tbl_bc_d   = tbl_bc_q;
    if (cfg_we && state_q == S_IDLE) begin
      tbl_base_d[cfg_idx] = cfg_base;
      tbl_len_d[cfg_idx]  = cfg_len;
      tbl_num_d[cfg_idx]  = cfg_num_rec;
      tbl_bc_d[cfg_idx]   = cfg_bcast;
    end
  end

  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    rec_d      = rec_q;
    elem_d     = elem_q;
    slot_d     = slot_q;
    rec_base_d = rec_base_q;
    words_d    = words_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR;
          layer_d = '0;
          rec_d   = '0;
        end
      end
      S_HDR: begin
        if (cur_empty) begin
          if (last_layer) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            layer_d = layer_q + 1'b1;
            rec_d   = '0;
          end
        end else begin
          state_d = S_FETCH;
          elem_d  = '0;
          slot_d  = '0;
          words_d = '0;
          if (rec_q == '0) rec_base_d = cur_base;
        end
      end
      S_FETCH: begin
        if (ext_valid) begin
          words_d[slot_q] = ext_data;
          elem_d          = elem_q + 1'b1;
          slot_d          = slot_q + 1'b1;
          if (slot_q == SW'(WPI - 1) || elem_q == cur_len - LEN_W'(1)) state_d = S_SEND;
        end
      end
      S_SEND: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (elem_q != cur_len) begin
          state_d = S_FETCH;
          slot_d  = '0;
          words_d = '0;
        end else if (!cur_bcast && rec_q != cur_num - LEN_W'(1)) begin
          state_d    = S_HDR;
          rec_d      = rec_q + 1'b1;
          rec_base_d = rec_base_q + ADDR_W'(cur_len);
        end else if (last_layer) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_HDR;
          layer_d = layer_q + 1'b1;
          rec_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a start in the same cycle.
    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      layer_d = '0;
      rec_d   = '0;
      elem_d  = '0;
      slot_d  = '0;
      words_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        tbl_base_q[i] <= '0;
        tbl_len_q[i]  <= '0;
        tbl_num_q[i]  <= '0;
        tbl_bc_q[i]   <= 1'b0;
      end
      state_q    <= S_IDLE;
      layer_q    <= '0;
      rec_q      <= '0;
      elem_q     <= '0;
      slot_q     <= '0;
      rec_base_q <= '0;
      words_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      tbl_base_q <= tbl_base_d;
      tbl_len_q  <= tbl_len_d;
      tbl_num_q  <= tbl_num_d;
      tbl_bc_q   <= tbl_bc_d;
      state_q    <= state_d;
      layer_q    <= layer_d;
      rec_q      <= rec_d;
      elem_q     <= elem_d;
      slot_q     <= slot_d;
      rec_base_q <= rec_base_d;
      words_q    <= words_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    hdr_words    = '0;
    hdr_words[0] = N_STORAGE'(cur_len);
    hdr_words[1] = N_STORAGE'(layer_q);
  end

  // Address is derived from registered state only, so it holds steady across wait cycles.
  always_comb begin
    hdr_drive  = (state_q == S_HDR) && !cur_empty;
    data_drive = (state_q == S_SEND);
    ext_req    = (state_q == S_FETCH);
    ext_addr   = ext_req ? (rec_base_q + ADDR_W'(elem_q)) : '0;
    bus_drive  = hdr_drive || data_drive;
    bus_op     = hdr_drive ? 4'(OP_START) : (data_drive ? 4'(OP_DATA) : 4'd0);
    bus_data   = hdr_drive ? hdr_words : (data_drive ? words_q : '0);
    bus_target = bus_drive ? TW'(int'(rec_q) % NUM_CIMS) : '0;
    bus_bcast  = bus_drive && cur_bcast;
    busy       = (state_q != S_IDLE);
    done       = done_q;
  end

endmodule

// File: tb/tb_param_streamer.sv
// Directed bench for param_streamer: a latency-configurable memory responder,
// a bus/address recorder, and hand-built expected instruction lists per scenario.
module tb_param_streamer;

  localparam int N_STORAGE  = 16;
  localparam int NUM_CIMS   = 64;
  localparam int WPI        = 3;
  localparam int NUM_LAYERS = 8;
  localparam int ADDR_W     = 15;
  localparam int LEN_W      = 7;
  localparam int TW         = 6;
  localparam int LW         = 3;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic                     abort = 1'b0;
  logic                     cfg_we = 1'b0;
  logic [LW-1:0]            cfg_idx = '0;
  logic [ADDR_W-1:0]        cfg_base = '0;
  logic [LEN_W-1:0]         cfg_len = '0;
  logic [LEN_W-1:0]         cfg_num_rec = '0;
  logic                     cfg_bcast = 1'b0;
  logic                     ext_req;
  logic [ADDR_W-1:0]        ext_addr;
  logic                     ext_valid = 1'b0;
  logic [N_STORAGE-1:0]     ext_data = '0;
  logic                     bus_drive;
  logic [3:0]               bus_op;
  logic [WPI*N_STORAGE-1:0] bus_data;
  logic [TW-1:0]            bus_target;
  logic                     bus_bcast;
  logic                     busy;
  logic                     done;

  param_streamer #(
    .N_STORAGE(N_STORAGE), .NUM_CIMS(NUM_CIMS), .WPI(WPI), .NUM_LAYERS(NUM_LAYERS),
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .OP_START(1), .OP_DATA(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_num_rec(cfg_num_rec), .cfg_bcast(cfg_bcast),
    .ext_req(ext_req), .ext_addr(ext_addr), .ext_valid(ext_valid), .ext_data(ext_data),
    .bus_drive(bus_drive), .bus_op(bus_op), .bus_data(bus_data), .bus_target(bus_target),
    .bus_bcast(bus_bcast), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0]       pulses [$];
  logic [63:0]       exp_p  [$];
  logic [ADDR_W-1:0] addrs  [$];
  logic [ADDR_W-1:0] exp_a  [$];
  int done_cycles = 0;
  int idle_bad    = 0;
  int unstable    = 0;
  int lat         = 0;
  int wait_cnt    = 0;
  bit rand_lat    = 1'b0;
  bit prev_req    = 1'b0;
  bit prev_set    = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] memf(input logic [ADDR_W-1:0] a);
    return {a, 1'b1} ^ 16'h3C5A;
  endfunction

  function automatic logic [47:0] d3(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    return {w2, w1, w0};
  endfunction

  function automatic logic [63:0] pk(input logic bc, input logic [5:0] tgt, input logic [3:0] op,
                                     input logic [47:0] data);
    return {5'b0, bc, tgt, op, data};
  endfunction

  // Memory responder and observer share one block so their ordering at the sampling edge is fixed.
  always @(negedge clk) begin
    if (!rst_n) begin
      ext_valid = 1'b0;
      ext_data  = '0;
      wait_cnt  = 0;
      lat       = 0;
      prev_req  = 1'b0;
      prev_set  = 1'b0;
    end else begin
      if (bus_drive) pulses.push_back(pk(bus_bcast, bus_target, bus_op, bus_data));
      else if (bus_op != 4'd0 || bus_data != '0 || bus_target != '0 || bus_bcast) idle_bad++;
      if (done) done_cycles++;
      if (ext_req && prev_req && !prev_set && ext_addr != prev_addr) unstable++;
      prev_set = 1'b0;
      if (ext_valid) begin
        ext_valid = 1'b0;
        wait_cnt  = 0;
        lat       = rand_lat ? int'($urandom_range(4, 0)) : 0;
      end else if (ext_req) begin
        if (wait_cnt >= lat) begin
          ext_valid = 1'b1;
          ext_data  = memf(ext_addr);
          addrs.push_back(ext_addr);
          prev_set  = 1'b1;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
      prev_req  = ext_req;
      prev_addr = ext_addr;
    end
  end

  task automatic clearObs();
    pulses.delete();
    addrs.delete();
    exp_p.delete();
    exp_a.delete();
    done_cycles = 0;
    idle_bad    = 0;
    unstable    = 0;
  endtask

  task automatic doReset();
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    clearObs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic writeLayer(input int idx, input int base, input int len, input int num, input bit bc);
    cfg_idx     = LW'(idx);
    cfg_base    = ADDR_W'(base);
    cfg_len     = LEN_W'(len);
    cfg_num_rec = LEN_W'(num);
    cfg_bcast   = bc;
    cfg_we      = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Pulses start, optionally pokes a table write plus a second start mid-stream, waits for done.
  task automatic applyStimulus(input string tag, input bit poke);
    bit got;
    got   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, ".busy"}, 64'(busy), 64'd1);
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (poke && i == 2) begin
        cfg_idx = '0; cfg_base = ADDR_W'(1000); cfg_len = LEN_W'(3); cfg_num_rec = LEN_W'(1);
        cfg_bcast = 1'b0; cfg_we = 1'b1; start = 1'b1;
      end
      @(negedge clk);
      cfg_we = 1'b0;
      start  = 1'b0;
    end
    checkOutput({tag, ".done_seen"}, 64'(got), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic checkRun(input string tag, input int exp_done);
    checkOutput({tag, ".n_pulses"}, 64'(pulses.size()), 64'(exp_p.size()));
    for (int i = 0; i < exp_p.size() && i < pulses.size(); i++)
      checkOutput($sformatf("%s.pulse%0d", tag, i), pulses[i], exp_p[i]);
    checkOutput({tag, ".n_addrs"}, 64'(addrs.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < addrs.size(); i++)
      checkOutput($sformatf("%s.addr%0d", tag, i), 64'(addrs[i]), 64'(exp_a[i]));
    checkOutput({tag, ".done_cycles"}, 64'(done_cycles), 64'(exp_done));
    checkOutput({tag, ".idle_zero"}, 64'(idle_bad), 64'd0);
    checkOutput({tag, ".addr_stable"}, 64'(unstable), 64'd0);
  endtask

  task automatic expectLayer0Basic();
    exp_p.push_back(pk(0, 0, 1, d3(16'd5, 16'd0, 16'd0)));
    exp_p.push_back(pk(0, 0, 2, d3(memf(100), memf(101), memf(102))));
    exp_p.push_back(pk(0, 0, 2, d3(memf(103), memf(104), 16'd0)));
    exp_p.push_back(pk(0, 1, 1, d3(16'd5, 16'd0, 16'd0)));
    exp_p.push_back(pk(0, 1, 2, d3(memf(105), memf(106), memf(107))));
    exp_p.push_back(pk(0, 1, 2, d3(memf(108), memf(109), 16'd0)));
    for (int a = 100; a < 110; a++) exp_a.push_back(ADDR_W'(a));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;

    doReset();
    checkOutput("RST.busy", 64'(busy), 64'd0);
    checkOutput("RST.done", 64'(done), 64'd0);
    checkOutput("RST.bus_drive", 64'(bus_drive), 64'd0);
    checkOutput("RST.ext_req", 64'(ext_req), 64'd0);
    checkOutput("RST.ext_addr", 64'(ext_addr), 64'd0);
    checkOutput("RST.bus_fields", {bus_bcast, bus_target, bus_op, bus_data}, 64'd0);

    $display("[TB] empty table");
    applyStimulus("EMPTY", 1'b0);
    checkRun("EMPTY", 1);

    $display("[TB] layer 0 two records, single-cycle memory");
    doReset();
    rand_lat = 1'b0;
    writeLayer(0, 100, 5, 2, 1'b0);
    expectLayer0Basic();
    applyStimulus("BASIC", 1'b0);
    checkRun("BASIC", 1);

    $display("[TB] broadcast layer 2");
    doReset();
    rand_lat = 1'b1;
    writeLayer(2, 200, 3, 10, 1'b1);
    exp_p.push_back(pk(1, 0, 1, d3(16'd3, 16'd2, 16'd0)));
    exp_p.push_back(pk(1, 0, 2, d3(memf(200), memf(201), memf(202))));
    for (int a = 200; a < 203; a++) exp_a.push_back(ADDR_W'(a));
    applyStimulus("BCAST", 1'b0);
    checkRun("BCAST", 1);

    $display("[TB] random latency, multiple layers, zero-length layer skipped");
    doReset();
    rand_lat = 1'b1;
    writeLayer(1, 300, 7, 1, 1'b0);
    writeLayer(3, 50, 2, 2, 1'b0);
    writeLayer(4, 500, 0, 3, 1'b0);
    exp_p.push_back(pk(0, 0, 1, d3(16'd7, 16'd1, 16'd0)));
    exp_p.push_back(pk(0, 0, 2, d3(memf(300), memf(301), memf(302))));
    exp_p.push_back(pk(0, 0, 2, d3(memf(303), memf(304), memf(305))));
    exp_p.push_back(pk(0, 0, 2, d3(memf(306), 16'd0, 16'd0)));
    exp_p.push_back(pk(0, 0, 1, d3(16'd2, 16'd3, 16'd0)));
    exp_p.push_back(pk(0, 0, 2, d3(memf(50), memf(51), 16'd0)));
    exp_p.push_back(pk(0, 1, 1, d3(16'd2, 16'd3, 16'd0)));
    exp_p.push_back(pk(0, 1, 2, d3(memf(52), memf(53), 16'd0)));
    for (int a = 300; a < 307; a++) exp_a.push_back(ADDR_W'(a));
    for (int a = 50; a < 54; a++) exp_a.push_back(ADDR_W'(a));
    applyStimulus("RANDLAT", 1'b0);
    checkRun("RANDLAT", 1);

    $display("[TB] abort during second DATA of a record");
    doReset();
    rand_lat = 1'b0;
    writeLayer(0, 100, 5, 2, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 500 && n < 2; i++) begin
      @(negedge clk);
      if (bus_drive && bus_op == 4'd2) n++;
    end
    checkOutput("ABORT.second_data_seen", 64'(n), 64'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("ABORT.busy", 64'(busy), 64'd0);
    checkOutput("ABORT.bus_drive", 64'(bus_drive), 64'd0);
    checkOutput("ABORT.ext_req", 64'(ext_req), 64'd0);
    repeat (20) @(negedge clk);
    checkOutput("ABORT.no_done", 64'(done_cycles), 64'd0);
    checkOutput("ABORT.pulses", 64'(pulses.size()), 64'd3);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("ABORT.beats_start", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    clearObs();
    expectLayer0Basic();
    applyStimulus("REPLAY", 1'b0);
    checkRun("REPLAY", 1);

    $display("[TB] address wrap with ignored busy write and start");
    doReset();
    rand_lat = 1'b0;
    writeLayer(0, 32766, 4, 1, 1'b0);
    exp_p.push_back(pk(0, 0, 1, d3(16'd4, 16'd0, 16'd0)));
    exp_p.push_back(pk(0, 0, 2, d3(memf(32766), memf(32767), memf(0))));
    exp_p.push_back(pk(0, 0, 2, d3(memf(1), 16'd0, 16'd0)));
    exp_a.push_back(ADDR_W'(32766));
    exp_a.push_back(ADDR_W'(32767));
    exp_a.push_back(ADDR_W'(0));
    exp_a.push_back(ADDR_W'(1));
    applyStimulus("WRAP", 1'b1);
    checkRun("WRAP", 1);
    pulses.delete();
    addrs.delete();
    done_cycles = 0;
    applyStimulus("WRAP2", 1'b0);
    checkRun("WRAP2", 1);

    $display("[TB] asynchronous reset mid-stream");
    doReset();
    writeLayer(0, 100, 5, 2, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ARST.busy", 64'(busy), 64'd0);
    checkOutput("ARST.bus_drive", 64'(bus_drive), 64'd0);
    checkOutput("ARST.ext_req", 64'(ext_req), 64'd0);
    @(negedge clk);
    clearObs();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("ARST.no_pulses", 64'(pulses.size()), 64'd0);
    checkOutput("ARST.no_done", 64'(done_cycles), 64'd0);
    applyStimulus("ARST_TBL", 1'b0);
    checkRun("ARST_TBL", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_streamer.md
PARAM_STREAMER -- requirements
Module: param_streamer

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  N_STORAGE, 16, parameter word width
  NUM_CIMS, 64, CiM count; target width TW = clog2(NUM_CIMS)
  WPI, 3, data words per bus instruction
  NUM_LAYERS, 8, layer-table depth; index width LW = clog2(NUM_LAYERS)
  ADDR_W, 15, external memory address width
  LEN_W, 7, record-length and record-count width
  OP_START, 1, bus opcode for stream start
  OP_DATA, 2, bus opcode for stream data
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
  clk  in  1  clock
  rst_n  in  1  asynchronous active-low reset
  start  in  1  begin streaming all layers
  abort  in  1  stop streaming immediately
  cfg_we  in  1  layer-table write strobe
  cfg_idx  in  LW  layer-table entry index
  cfg_base  in  ADDR_W  entry base address
  cfg_len  in  LEN_W  words per record
  cfg_num_rec  in  LEN_W  records per layer
  cfg_bcast  in  1  entry broadcast flag
  ext_req  out  1  memory read request
  ext_addr  out  ADDR_W  memory read address
  ext_valid  in  1  memory data valid
  ext_data  in  N_STORAGE  memory read data
  bus_drive  out  1  bus instruction valid
  bus_op  out  4  bus opcode
  bus_data  out  WPI*N_STORAGE  packed bus data; word 0 in LSBs
  bus_target  out  TW  destination CiM
  bus_bcast  out  1  instruction addressed to all CiMs
  busy  out  1  streaming in progress
  done  out  1  completion pulse
REQ-003 Reset rst_n SHALL be asynchronous, active-low; clock clk.

Function
REQ-004 SHALL hold a NUM_LAYERS-entry layer table {base, len, num_rec, bcast}; cfg_we writes entry cfg_idx when not busy; writes while busy SHALL be ignored.
REQ-005 FSM states SHALL be IDLE, HDR, FETCH, SEND, NEXT; start in IDLE SHALL go to HDR at layer 0, record 0; start while busy SHALL be ignored.
REQ-006 Layers with num_rec = 0 or len = 0 SHALL be skipped without any bus or memory activity.
REQ-007 HDR SHALL pulse bus_drive one cycle with bus_op = OP_START, word 0 = len, word 1 = layer index, other words 0, then go to FETCH.
REQ-008 FETCH SHALL assert ext_req with ext_addr = base + rec*len + elem; ext_req and ext_addr SHALL stay stable until ext_valid is sampled high; ext_valid while ext_req is low SHALL be ignored.
REQ-009 A captured word SHALL be placed in slot (elem mod WPI); when WPI words are captured, or the record's last word is captured, SHALL go to SEND.
REQ-010 SEND SHALL pulse bus_drive one cycle with bus_op = OP_DATA, unfilled slots zero-padded; the instruction SHALL issue on the cycle after the completing ext_valid.
REQ-011 bus_target SHALL equal the record index (mod NUM_CIMS); bus_bcast SHALL equal the entry's bcast flag; in broadcast mode the layer SHALL stream exactly one record regardless of num_rec.
REQ-012 NEXT SHALL advance elem, then record (issuing a new HDR), then layer; after layer NUM_LAYERS-1 SHALL pulse done one cycle and return to IDLE.
REQ-013 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-014 abort SHALL, on the next edge, force IDLE, deassert ext_req, bus_drive, and busy, discard partial data, and emit no done; abort takes priority over simultaneous start.
REQ-015 busy SHALL be high in every non-IDLE state; bus_op, bus_data, bus_target, and bus_bcast SHALL be 0 whenever bus_drive is low.

Reset
REQ-016 Reset SHALL force IDLE and zero all outputs, counters, and data registers; the layer table SHALL reset to all-zero entries.
REQ-017 Reset asserted mid-stream SHALL take effect asynchronously, with no further bus pulses after release until a new start.

Verification
REQ-018 Layer 0 = {base 100, len 5, num_rec 2, bcast 0}, other layers empty, 1-cycle memory -> per record: START(len 5), DATA(w0..w2), DATA(w3, w4, 0); addresses 100..109; targets 0, 1; one done pulse.
REQ-019 Layer 2 bcast = 1, num_rec 10, len 3 -> one START and one DATA with bus_bcast = 1, addresses base..base+2.
REQ-020 Memory latency 0..4 cycles, random -> ext_addr stable while ext_req is high; data order matches memory contents.
REQ-021 abort during the second DATA of a record -> next cycle IDLE, busy 0, no done; a new start replays from layer 0.
REQ-022 cfg_we and start in the same busy cycle, and base = 2^ADDR_W-2 with len 4 -> write ignored, start ignored, addresses wrap to 0 and 1.
